// File: rtl/mc_common_pkg.sv
// Types and constants shared by the L1/L2 memory interface.
// L1 caches and L2 responders all use this package.
package mc_common_pkg;

  typedef logic [31:0] xlen_t;

  typedef struct packed {
    logic  valid;
    logic  wr;
    xlen_t addr;
    xlen_t wdata;
    logic  atomic;
    logic  is_ifetch;
  } mem_req_t;

  typedef struct packed {
    logic  valid;
    xlen_t rdata;
    logic  sc_success;
  } mem_resp_t;

  typedef struct packed {
    xlen_t rdata;
    logic  sc_success;
  } resp_payload_t;

  localparam int L2_RESP_LATENCY = 1;

  typedef enum logic [1:0] {RC_READ, RC_LL, RC_WRITE, RC_SC} req_class_e;

  // An instruction fetch is always a plain read, whatever its wr/atomic bits say.
  function automatic req_class_e classify(input logic wr, input logic atomic,
                                          input logic is_ifetch);
    if (is_ifetch) return RC_READ;
    if (wr) return atomic ? RC_SC : RC_WRITE;
    return atomic ? RC_LL : RC_READ;
  endfunction

endpackage

// File: rtl/resp_delay_pipe.sv
// Fixed-depth shift register for a valid flag plus payload.
// A synchronous clear drops everything in flight.
module resp_delay_pipe #(
  parameter int  STAGES = 1,
  parameter type T      = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic d_valid,
  input  T     d_data,
  output logic q_valid,
  output T     q_data
);

  logic [STAGES-1:0] valid_q;
  T                  data_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= d_valid;
      for (int i = 1; i < STAGES; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // Payload is not cleared; consumers qualify it with q_valid.
  always_ff @(posedge clk) begin
    data_q[0] <= d_data;
    for (int i = 1; i < STAGES; i++) data_q[i] <= data_q[i-1];
  end

  assign q_valid = valid_q[STAGES-1];
  assign q_data  = data_q[STAGES-1];

endmodule

// File: rtl/l2_mem_responder.sv
// L2-side responder for the L1 memory interface: word array, in-order fixed-latency
// responses, LL/SC reservation enforced at the memory, saturating out-of-range counter.
module l2_mem_responder
  import mc_common_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = L2_RESP_LATENCY,
  parameter int ERR_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  mem_req_t         req,
  output mem_resp_t        resp,
  output logic [ERR_W-1:0] err_count,
  output logic             resv_valid,
  output xlen_t            resv_addr
);

  localparam int IDX_W = $clog2(DEPTH);

  xlen_t         mem [DEPTH];
  logic [IDX_W-1:0] idx;
  xlen_t         word_addr;
  logic          in_range;
  logic          resv_hit;
  logic          do_write;
  req_class_e    rclass;
  resp_payload_t s1_data;
  logic          s1_valid;
  resp_payload_t out_data;
  logic          out_valid;
  logic          unused_low_bits;

  assign idx             = req.addr[IDX_W+1:2];
  assign word_addr       = {req.addr[31:2], 2'b00};
  assign in_range        = ~|req.addr[31:IDX_W+2];
  assign rclass          = classify(req.wr, req.atomic, req.is_ifetch);
  assign resv_hit        = resv_valid && (word_addr == resv_addr);
  assign unused_low_bits = ^req.addr[1:0];

  // A failed SC and anything out of range must leave the array untouched.
  assign do_write = req.valid && !rst && in_range &&
                    ((rclass == RC_WRITE) || (rclass == RC_SC && resv_hit));

  always_ff @(posedge clk) begin
    if (do_write) mem[idx] <= req.wdata;
  end

  // First response stage: the read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid           <= req.valid;
      s1_data.rdata      <= (req.valid && in_range && (rclass == RC_READ || rclass == RC_LL))
                            ? mem[idx] : '0;
      s1_data.sc_success <= req.valid && (rclass == RC_SC) && resv_hit && in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resv_valid <= 1'b0;
      resv_addr  <= '0;
    end else if (req.valid) begin
      case (rclass)
        RC_LL: begin
          resv_valid <= 1'b1;
          resv_addr  <= word_addr;
        end
        RC_WRITE: if (resv_hit) resv_valid <= 1'b0;
        RC_SC:    resv_valid <= 1'b0;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (req.valid && !in_range && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

  generate
    if (LATENCY <= 1) begin : g_direct
      assign out_valid = s1_valid;
      assign out_data  = s1_data;
    end else begin : g_pipe
      resp_delay_pipe #(
        .STAGES (LATENCY - 1),
        .T      (resp_payload_t)
      ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .d_valid (s1_valid),
        .d_data  (s1_data),
        .q_valid (out_valid),
        .q_data  (out_data)
      );
    end
  endgenerate

  // Idle cycles present an all-zero response.
  always_comb begin
    resp            = '0;
    resp.valid      = out_valid;
    resp.rdata      = out_valid ? out_data.rdata : '0;
    resp.sc_success = out_valid && out_data.sc_success;
  end

endmodule

// File: tb/tb_l2_mem_responder.sv
// Scoreboard bench for l2_mem_responder: a LATENCY=1 default instance and a small
// LATENCY=3 instance for saturation and reset-drop behaviour.
module tb_l2_mem_responder;
  import mc_common_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic      rst0, rst1;
  mem_req_t  req0, req1;
  mem_resp_t resp0, resp1;
  logic [15:0] err0;
  logic [3:0]  err1;
  logic      rv0, rv1;
  xlen_t     ra0, ra1;

  typedef struct {
    xlen_t rdata;
    logic  sc;
    int    cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   cycle = 0;
  int   tests = 0;
  int   fails = 0;

  l2_mem_responder #(.DEPTH(1024), .LATENCY(1), .ERR_W(16)) dut0 (
    .clk(clk), .rst(rst0), .req(req0), .resp(resp0),
    .err_count(err0), .resv_valid(rv0), .resv_addr(ra0)
  );

  l2_mem_responder #(.DEPTH(16), .LATENCY(3), .ERR_W(4)) dut1 (
    .clk(clk), .rst(rst1), .req(req1), .resp(resp1),
    .err_count(err1), .resv_valid(rv1), .resv_addr(ra1)
  );

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input xlen_t actual, input xlen_t expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Monitor: pops one expected response whenever a DUT presents resp.valid.
  always @(negedge clk) begin
    if (resp0.valid) begin
      if (q0.size() == 0) begin
        checkOutput("d0 unexpected resp", 32'(resp0.valid), 32'h0);
      end else begin
        e0 = q0.pop_front();
        checkOutput("d0 rdata", resp0.rdata, e0.rdata);
        checkOutput("d0 sc_success", 32'(resp0.sc_success), 32'(e0.sc));
        checkOutput("d0 latency", xlen_t'(cycle), xlen_t'(e0.cyc));
      end
    end
    if (resp1.valid) begin
      if (q1.size() == 0) begin
        checkOutput("d1 unexpected resp", 32'(resp1.valid), 32'h0);
      end else begin
        e1 = q1.pop_front();
        checkOutput("d1 rdata", resp1.rdata, e1.rdata);
        checkOutput("d1 sc_success", 32'(resp1.sc_success), 32'(e1.sc));
        checkOutput("d1 latency", xlen_t'(cycle), xlen_t'(e1.cyc));
      end
    end
  end

  task automatic applyStimulus(input bit sel, input logic wr, input logic atomic,
                               input logic ifetch, input xlen_t addr, input xlen_t wdata,
                               input xlen_t exp_rdata, input logic exp_sc);
    mem_req_t r;
    exp_t     e;
    r = '{valid:1'b1, wr:wr, addr:addr, wdata:wdata, atomic:atomic, is_ifetch:ifetch};
    @(negedge clk);
    e.rdata = exp_rdata;
    e.sc    = exp_sc;
    if (sel == 1'b0) begin
      e.cyc = cycle + 1;
      req0  = r;
      req1.valid = 1'b0;
      q0.push_back(e);
    end else begin
      e.cyc = cycle + 3;
      req1  = r;
      req0.valid = 1'b0;
      q1.push_back(e);
    end
  endtask

  task automatic doRead(input bit sel, input xlen_t addr, input xlen_t exp_rdata);
    applyStimulus(sel, 1'b0, 1'b0, 1'b0, addr, 32'h0, exp_rdata, 1'b0);
  endtask

  task automatic doWrite(input bit sel, input xlen_t addr, input xlen_t wdata);
    applyStimulus(sel, 1'b1, 1'b0, 1'b0, addr, wdata, 32'h0, 1'b0);
  endtask

  task automatic doLL(input bit sel, input xlen_t addr, input xlen_t exp_rdata);
    applyStimulus(sel, 1'b0, 1'b1, 1'b0, addr, 32'h0, exp_rdata, 1'b0);
  endtask

  task automatic doSC(input bit sel, input xlen_t addr, input xlen_t wdata, input logic exp_sc);
    applyStimulus(sel, 1'b1, 1'b1, 1'b0, addr, wdata, 32'h0, exp_sc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req0.valid = 1'b0;
      req1.valid = 1'b0;
    end
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    req0 = '0;
    req1 = '0;
    repeat (3) @(negedge clk);
    checkOutput("d0 reset resp", 32'(resp0.valid), 32'h0);
    checkOutput("d0 reset err", 32'(err0), 32'h0);
    checkOutput("d0 reset resv_valid", 32'(rv0), 32'h0);
    checkOutput("d0 reset resv_addr", ra0, 32'h0);
    rst0 = 1'b0;
    rst1 = 1'b0;

    doWrite(0, 32'h10, 32'hDEADBEEF);
    doRead(0, 32'h10, 32'hDEADBEEF);
    doRead(0, 32'h13, 32'hDEADBEEF);
    doWrite(0, 32'hFFC, 32'h00C0FFEE);
    doRead(0, 32'hFFC, 32'h00C0FFEE);

    doWrite(0, 32'h20, 32'h77);
    doLL(0, 32'h20, 32'h77);
    idle(1);
    checkOutput("d0 LL resv_valid", 32'(rv0), 32'h1);
    checkOutput("d0 LL resv_addr", ra0, 32'h20);
    doSC(0, 32'h20, 32'h1234, 1'b1);
    doRead(0, 32'h20, 32'h1234);
    idle(1);
    checkOutput("d0 resv after SC", 32'(rv0), 32'h0);

    doLL(0, 32'h20, 32'h1234);
    doWrite(0, 32'h20, 32'h5);
    doSC(0, 32'h20, 32'h9, 1'b0);
    doRead(0, 32'h20, 32'h5);

    doWrite(0, 32'h24, 32'hAA);
    doLL(0, 32'h20, 32'h5);
    doLL(0, 32'h24, 32'hAA);
    idle(1);
    checkOutput("d0 LL overwrite resv_addr", ra0, 32'h24);
    doSC(0, 32'h20, 32'h111, 1'b0);
    doSC(0, 32'h24, 32'h222, 1'b0);
    doRead(0, 32'h24, 32'hAA);
    doRead(0, 32'h20, 32'h5);

    // An ifetch with wr/atomic set is a plain read: no write, reservation intact.
    doLL(0, 32'h24, 32'hAA);
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h24, 32'hFF, 32'hAA, 1'b0);
    doSC(0, 32'h24, 32'h333, 1'b1);
    doRead(0, 32'h24, 32'h333);

    doWrite(0, 32'h0, 32'h11);
    doRead(0, 32'h1000, 32'h0);
    doLL(0, 32'h0, 32'h11);
    doSC(0, 32'h1000, 32'h99, 1'b0);
    idle(1);
    checkOutput("d0 err after 2 oor", 32'(err0), 32'h2);
    checkOutput("d0 resv after oor SC", 32'(rv0), 32'h0);
    doWrite(0, 32'h1000, 32'h55);
    doRead(0, 32'h0, 32'h11);
    idle(2);
    checkOutput("d0 err after 3 oor", 32'(err0), 32'h3);
    checkOutput("d0 idle resp valid", 32'(resp0.valid), 32'h0);
    checkOutput("d0 idle resp rdata", resp0.rdata, 32'h0);

    // A write presented during reset must be ignored.
    @(negedge clk);
    rst0 = 1'b1;
    req0 = '{valid:1'b1, wr:1'b1, addr:32'h10, wdata:32'h1, atomic:1'b0, is_ifetch:1'b0};
    @(negedge clk);
    rst0 = 1'b0;
    req0.valid = 1'b0;
    checkOutput("d0 err after rst", 32'(err0), 32'h0);
    checkOutput("d0 resp after rst", 32'(resp0.valid), 32'h0);
    doRead(0, 32'h10, 32'hDEADBEEF);
    idle(2);

    doWrite(1, 32'h4, 32'hA1);
    doWrite(1, 32'h8, 32'hB2);
    doLL(1, 32'h8, 32'hB2);
    for (int i = 0; i < 19; i++) doRead(1, 32'h40, 32'h0);
    idle(4);
    checkOutput("d1 err saturated", 32'(err1), 32'hF);
    checkOutput("d1 resv_valid before rst", 32'(rv1), 32'h1);

    doRead(1, 32'h4, 32'hA1);
    doRead(1, 32'h4, 32'hA1);
    doRead(1, 32'h4, 32'hA1);
    idle(1);
    @(negedge clk);
    #1 rst1 = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("d1 in-flight at rst", xlen_t'(q1.size()), 32'h1);
    q1.delete();
    @(negedge clk);
    checkOutput("d1 resp after rst", 32'(resp1.valid), 32'h0);
    rst1 = 1'b0;
    idle(6);
    checkOutput("d1 err after rst", 32'(err1), 32'h0);
    checkOutput("d1 resv_valid after rst", 32'(rv1), 32'h0);
    checkOutput("d1 resv_addr after rst", ra1, 32'h0);

    idle(2);
    checkOutput("d0 queue drained", xlen_t'(q0.size()), 32'h0);
    checkOutput("d1 queue drained", xlen_t'(q1.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
